// File: rtl/bus_mux4_arbiter_pkg.sv
// rtl/bus_mux4_arbiter_pkg.sv - shared encodings and round-robin pick for the 4-way bus arbiter
package bus_mux4_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Returns {found, index} of the first set request at or after ptr, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        logic             found;
        idx   = ptr;
        found = 1'b0;
        // Walk from the farthest offset down so the nearest set bit wins last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/bus_mux4_arbiter_mux.sv
// rtl/bus_mux4_arbiter_mux.sv - W-bit 4:1 combinational multiplexer built from 1-bit slices
module bus_mux4
    import bus_mux4_arbiter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    input  logic [IDX_W-1:0] sel,
    output logic [W-1:0]     y
);

    for (genvar b = 0; b < W; b++) begin : g_slice
        logic [NUM_REQ-1:0] slice;
        assign slice = {d3[b], d2[b], d1[b], d0[b]};
        assign y[b]  = slice[sel];
    end

endmodule

// File: rtl/bus_mux4_arbiter.sv
// rtl/bus_mux4_arbiter.sv - round-robin arbiter with hold limit owning a shared 4:1 bus mux
module bus_mux4_arbiter
    import bus_mux4_arbiter_pkg::*;
#(
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] din0,
    input  logic [W-1:0] din1,
    input  logic [W-1:0] din2,
    input  logic [W-1:0] din3,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic [W-1:0] dout,
    output logic         dout_valid
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t         state, state_nx;
    logic [1:0]     ptr, ptr_nx;
    logic [3:0]     hold_cnt, hold_nx;
    logic [1:0]     sel_nx;
    logic [3:0]     gnt_nx;
    logic           take;
    logic [IDX_W:0] pick;
    logic           owner_req;
    logic           others;
    logic [W-1:0]   mux_out;

    bus_mux4 #(.W(W)) u_mux (
        .d0  (din0),
        .d1  (din1),
        .d2  (din2),
        .d3  (din3),
        .sel (sel),
        .y   (mux_out)
    );

    assign owner_req = req[sel];
    assign others    = |(req & ~(4'b0001 << sel));
    assign pick      = rr_pick(req, ptr);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        hold_nx  = hold_cnt;
        sel_nx   = sel;
        gnt_nx   = gnt;
        take     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick[IDX_W]) take = 1'b1;
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    if (pick[IDX_W]) begin
                        take = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                        gnt_nx   = '0;
                    end
                end else if (hold_cnt == HOLD_LAST && others) begin
                    // ptr already sits past the owner, so the pick is another requester.
                    take = 1'b1;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nx = hold_cnt + 4'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                gnt_nx   = '0;
            end
        endcase
        if (take) begin
            state_nx = ST_GRANT;
            sel_nx   = pick[IDX_W-1:0];
            gnt_nx   = 4'b0001 << pick[IDX_W-1:0];
            ptr_nx   = pick[IDX_W-1:0] + 2'd1;
            hold_nx  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            sel      <= '0;
            gnt      <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            hold_cnt <= hold_nx;
            sel      <= sel_nx;
            gnt      <= gnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (state == ST_GRANT && owner_req) begin
            dout       <= mux_out;
            dout_valid <= 1'b1;
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule
